// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared word width and ALU operation codes
package mips_alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [4:0] {
        OP_AND   = 5'd0,
        OP_OR    = 5'd1,
        OP_ADD   = 5'd2,
        OP_XOR   = 5'd3,
        OP_NOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SUB   = 5'd6,
        OP_SLT   = 5'd7,
        OP_SRL   = 5'd8,
        OP_SRA   = 5'd9,
        OP_SLLV  = 5'd10,
        OP_SRLV  = 5'd11,
        OP_SRAV  = 5'd12,
        OP_SLTU  = 5'd13,
        OP_LUI   = 5'd14,
        OP_MULT  = 5'd15,
        OP_MULTU = 5'd16,
        OP_DIV   = 5'd17,
        OP_DIVU  = 5'd18
    } alu_op_e;

endpackage

// File: rtl/mips_alu_if.sv
// rtl/mips_alu_if.sv - operand/result bundle between the ALU wrapper and its core
interface mips_alu_if;
    import mips_alu_pkg::*;

    logic [WIDTH-1:0]   srca;
    logic [WIDTH-1:0]   srcb;
    logic [4:0]         shamt;
    logic [4:0]         alucontrol;
    logic [WIDTH-1:0]   aluout;
    logic               zero;
    logic [2*WIDTH-1:0] bigresult;

    modport master (
        output srca, srcb, shamt, alucontrol,
        input  aluout, zero, bigresult
    );

    modport slave (
        input  srca, srcb, shamt, alucontrol,
        output aluout, zero, bigresult
    );

endinterface

// File: rtl/mips_alu_core.sv
// rtl/mips_alu_core.sv - combinational ALU operation decode, multiply and divide
module alu_core
    import mips_alu_pkg::*;
(
    mips_alu_if.slave bus
);

    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic [4:0]                vsh;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          quo_s;
    logic [WIDTH-1:0]          rem_s;
    logic [WIDTH-1:0]          quo_u;
    logic [WIDTH-1:0]          rem_u;
    logic [WIDTH-1:0]          res;
    logic [2*WIDTH-1:0]        big;

    assign a   = bus.srca;
    assign b   = bus.srcb;
    assign vsh = a[4:0];

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Divide-by-zero and the single signed overflow case are pinned to fixed results
    always_comb begin
        quo_s = '1;
        rem_s = a;
        if (b != '0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quo_s = 32'h8000_0000;
                rem_s = '0;
            end else begin
                quo_s = $signed(a) / $signed(b);
                rem_s = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        quo_u = '1;
        rem_u = a;
        if (b != '0) begin
            quo_u = a / b;
            rem_u = a % b;
        end
    end

    always_comb begin
        res = '0;
        big = '0;
        case (bus.alucontrol)
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_ADD:   res = a + b;
            OP_XOR:   res = a ^ b;
            OP_NOR:   res = ~(a | b);
            OP_SUB:   res = a - b;
            OP_SLL:   res = b << bus.shamt;
            OP_SRL:   res = b >> bus.shamt;
            OP_SRA:   res = $signed(b) >>> bus.shamt;
            OP_SLLV:  res = b << vsh;
            OP_SRLV:  res = b >> vsh;
            OP_SRAV:  res = $signed(b) >>> vsh;
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:   res = b << 16;
            OP_MULT:  big = prod_s;
            OP_MULTU: big = prod_u;
            OP_DIV:   big = {rem_s, quo_s};
            OP_DIVU:  big = {rem_u, quo_u};
            default:  ;
        endcase
    end

    assign bus.aluout    = res;
    assign bus.zero      = (res == '0);
    assign bus.bigresult = big;

endmodule

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - MIPS ALU with address adder, zero extender and registered result copies
module mips_alu #(
    parameter int WIDTH = mips_alu_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic [4:0]         shamt,
    input  logic [4:0]         alucontrol,
    output logic [WIDTH-1:0]   aluout,
    output logic               zero,
    output logic [2*WIDTH-1:0] bigresult,
    input  logic [WIDTH-1:0]   add_a,
    input  logic [WIDTH-1:0]   add_b,
    output logic [WIDTH-1:0]   add_y,
    input  logic [15:0]        ext_in,
    output logic [WIDTH-1:0]   ext_out,
    output logic [WIDTH-1:0]   aluout_q,
    output logic               zero_q,
    output logic [2*WIDTH-1:0] bigresult_q
);

    mips_alu_if core_bus ();

    assign core_bus.srca       = srca;
    assign core_bus.srcb       = srcb;
    assign core_bus.shamt      = shamt;
    assign core_bus.alucontrol = alucontrol;

    alu_core u_core (
        .bus (core_bus)
    );

    assign aluout    = core_bus.aluout;
    assign zero      = core_bus.zero;
    assign bigresult = core_bus.bigresult;

    assign add_y   = add_a + add_b;
    assign ext_out = {{(WIDTH-16){1'b0}}, ext_in};

    // Reset value mirrors an all-zero result, hence zero_q is held high
    always_ff @(posedge clk) begin
        if (reset) begin
            aluout_q    <= '0;
            zero_q      <= 1'b1;
            bigresult_q <= '0;
        end else begin
            aluout_q    <= aluout;
            zero_q      <= zero;
            bigresult_q <= bigresult;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - randomized self-checking bench for mips_alu against a behavioural model
module tb_mips_alu;

    logic        clk;
    logic        reset;
    logic [31:0] add_a, add_b, add_y;
    logic [15:0] ext_in;
    logic [31:0] ext_out;
    logic [31:0] aluout_q;
    logic        zero_q;
    logic [63:0] bigresult_q;

    mips_alu_if bus ();

    mips_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .srca        (bus.srca),
        .srcb        (bus.srcb),
        .shamt       (bus.shamt),
        .alucontrol  (bus.alucontrol),
        .aluout      (bus.aluout),
        .zero        (bus.zero),
        .bigresult   (bus.bigresult),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_y       (add_y),
        .ext_in      (ext_in),
        .ext_out     (ext_out),
        .aluout_q    (aluout_q),
        .zero_q      (zero_q),
        .bigresult_q (bigresult_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    bit run = 1'b0;
    bit q_valid = 1'b0;
    logic [31:0] exp_aluout_q;
    logic        exp_zero_q;
    logic [63:0] exp_big_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: {aluout, bigresult} from plain integer arithmetic
    function automatic logic [95:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        int ia = a;
        int ib = b;
        longint sa = ia;
        longint sb = ib;
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint q = 0;
        longint r = 0;
        longint unsigned uq = 0;
        longint unsigned ur = 0;
        logic [31:0] y = 0;
        logic [63:0] big = 0;
        case (op)
            5'd0:  y = a & b;
            5'd1:  y = a | b;
            5'd2:  y = a + b;
            5'd3:  y = a ^ b;
            5'd4:  y = ~(a | b);
            5'd5:  y = b << sh;
            5'd6:  y = a - b;
            5'd7:  y = (ia < ib) ? 32'd1 : 32'd0;
            5'd8:  y = b >> sh;
            5'd9:  y = ib >>> sh;
            5'd10: y = b << (a % 32);
            5'd11: y = b >> (a % 32);
            5'd12: y = ib >>> (a % 32);
            5'd13: y = (ua < ub) ? 32'd1 : 32'd0;
            5'd14: y = b * 32'd65536;
            5'd15: big = sa * sb;
            5'd16: big = ua * ub;
            5'd17: begin
                if (b == 0) big = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa - q * sb;
                    big = {r[31:0], q[31:0]};
                end
            end
            5'd18: begin
                if (b == 0) big = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua - uq * ub;
                    big = {ur[31:0], uq[31:0]};
                end
            end
            default: ;
        endcase
        return {y, big};
    endfunction

    always @(posedge clk) begin
        logic [95:0] m;
        m = model(bus.alucontrol, bus.srca, bus.srcb, bus.shamt);
        if (reset) begin
            exp_aluout_q = 32'd0;
            exp_zero_q   = 1'b1;
            exp_big_q    = 64'd0;
        end else begin
            exp_aluout_q = m[95:64];
            exp_zero_q   = (m[95:64] == 32'd0);
            exp_big_q    = m[63:0];
        end
        q_valid = 1'b1;
    end

    always @(negedge clk) begin
        logic [95:0] m;
        if (run) begin
            m = model(bus.alucontrol, bus.srca, bus.srcb, bus.shamt);
            check("aluout", {32'd0, bus.aluout}, {32'd0, m[95:64]});
            check("zero", {63'd0, bus.zero}, {63'd0, m[95:64] == 32'd0});
            check("bigresult", bus.bigresult, m[63:0]);
            check("add_y", {32'd0, add_y}, {32'd0, add_a + add_b});
            check("ext_out", {32'd0, ext_out}, {48'd0, ext_in});
            if (q_valid) begin
                check("aluout_q", {32'd0, aluout_q}, {32'd0, exp_aluout_q});
                check("zero_q", {63'd0, zero_q}, {63'd0, exp_zero_q});
                check("bigresult_q", bigresult_q, exp_big_q);
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(posedge clk);
        #1;
        bus.alucontrol = op;
        bus.srca       = a;
        bus.srcb       = b;
        bus.shamt      = sh;
        #2;
    endtask

    task automatic randomize_inputs();
        bus.alucontrol = $urandom_range(0, 31);
        bus.srca       = pick();
        bus.srcb       = pick();
        bus.shamt      = $urandom_range(0, 31);
        add_a          = $urandom;
        add_b          = $urandom;
        ext_in         = $urandom;
    endtask

    initial begin
        logic [95:0] pin;
        reset = 1'b1;
        bus.alucontrol = 5'd0;
        bus.srca = 32'd0;
        bus.srcb = 32'd0;
        bus.shamt = 5'd0;
        add_a = 32'd0;
        add_b = 32'd0;
        ext_in = 16'd0;

        pin = model(5'd17, 32'hFFFF_FFF9, 32'd2, 5'd0);
        check("pin_div", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFD);
        pin = model(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        check("pin_div_ovf", pin[63:0], 64'h0000_0000_8000_0000);
        pin = model(5'd9, 32'd0, 32'h8000_0000, 5'd4);
        check("pin_sra", {32'd0, pin[95:64]}, 64'h0000_0000_F800_0000);

        repeat (2) @(posedge clk);
        #3;
        run = 1'b1;
        check("rst_aluout_q", {32'd0, aluout_q}, 64'd0);
        check("rst_zero_q", {63'd0, zero_q}, 64'd1);
        check("rst_bigresult_q", bigresult_q, 64'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        add_a = 32'h0040_0004;
        add_b = 32'hFFFF_FFF0;
        ext_in = 16'h8001;
        bus.alucontrol = 5'd2;
        bus.srca = 32'd2;
        bus.srcb = 32'd3;
        @(posedge clk);
        #2;
        check("lit_add_q", {32'd0, aluout_q}, 64'd5);
        check("lit_add_y", {32'd0, add_y}, 64'h0000_0000_003F_FFF4);
        check("lit_ext_out", {32'd0, ext_out}, 64'h0000_0000_0000_8001);

        apply(5'd2, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("lit_add_wrap", {31'd0, bus.zero, bus.aluout}, 64'h1_0000_0000);
        apply(5'd6, 32'd5, 32'd7, 5'd0);
        check("lit_sub", {31'd0, bus.zero, bus.aluout}, 64'h0_FFFF_FFFE);
        apply(5'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("lit_slt", {32'd0, bus.aluout}, 64'd1);
        apply(5'd13, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("lit_sltu", {32'd0, bus.aluout}, 64'd0);
        apply(5'd9, 32'd0, 32'h8000_0000, 5'd4);
        check("lit_sra", {32'd0, bus.aluout}, 64'h0000_0000_F800_0000);
        apply(5'd11, 32'd36, 32'h8000_0000, 5'd0);
        check("lit_srlv", {32'd0, bus.aluout}, 64'h0000_0000_0800_0000);
        apply(5'd14, 32'd0, 32'h1234, 5'd0);
        check("lit_lui", {32'd0, bus.aluout}, 64'h0000_0000_1234_0000);
        apply(5'd15, 32'hFFFF_FFFE, 32'd3, 5'd0);
        check("lit_mult", bus.bigresult, 64'hFFFF_FFFF_FFFF_FFFA);
        check("lit_mult_aluout", {32'd0, bus.aluout}, 64'd0);
        apply(5'd17, 32'hFFFF_FFF9, 32'd2, 5'd0);
        check("lit_div", bus.bigresult, 64'hFFFF_FFFF_FFFF_FFFD);
        apply(5'd18, 32'd9, 32'd0, 5'd0);
        check("lit_divu0", bus.bigresult, 64'h0000_0009_FFFF_FFFF);
        apply(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        check("lit_div_ovf", bus.bigresult, 64'h0000_0000_8000_0000);
        apply(5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        check("lit_undef", {31'd0, bus.zero, bus.aluout}, 64'h1_0000_0000);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            randomize_inputs();
            if (i == 700) reset = 1'b1;
            if (i == 703) reset = 1'b0;
        end

        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.alucontrol = 5'd2;
        bus.srca = 32'd2;
        bus.srcb = 32'd3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_aluout_q", {32'd0, aluout_q}, 64'd0);
        check("midrst_comb", {32'd0, bus.aluout}, 64'd5);
        @(posedge clk);
        #2;
        check("midrst_resume", {32'd0, aluout_q}, 64'd5);

        @(posedge clk);
        #1;
        run = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the datapath word width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port srca, input, 32 bits, ALU operand A.
REQ-005 The block SHALL have port srcb, input, 32 bits, ALU operand B.
REQ-006 The block SHALL have port shamt, input, 5 bits, the constant shift amount (instr[10:6]).
REQ-007 The block SHALL have port alucontrol, input, 5 bits, the operation select.
REQ-008 The block SHALL have port aluout, output, 32 bits, the combinational result.
REQ-009 The block SHALL have port zero, output, 1 bit, high when aluout equals 0.
REQ-010 The block SHALL have port bigresult, output, 64 bits, the combinational multiply/divide result {hi,lo}.
REQ-011 The block SHALL have ports add_a and add_b, input, 32 bits each, and add_y, output, 32 bits, forming the standalone address adder.
REQ-012 The block SHALL have port ext_in, input, 16 bits, and ext_out, output, 32 bits, forming the zero extender.
REQ-013 The block SHALL have ports aluout_q (output, 32 bits), zero_q (output, 1 bit) and bigresult_q (output, 64 bits), each a registered copy of its combinational counterpart.

Function
REQ-014 The block SHALL drive add_y = (add_a + add_b) mod 2^32 combinationally, with no carry or overflow output.
REQ-015 The block SHALL drive ext_out = {16'h0000, ext_in} combinationally.
REQ-016 The block SHALL implement the following alucontrol codes, all combinational:
- 0 AND; 1 OR; 2 ADD (wraps, no trap); 3 XOR; 4 NOR; 6 SUB (wraps)
- 5 SLL: srcb << shamt; 8 SRL: srcb >> shamt (logical); 9 SRA: srcb >>> shamt (arithmetic)
- 10 SLLV, 11 SRLV, 12 SRAV: shift srcb by srca[4:0]
- 7 SLT: 1 if srca < srcb signed, else 0; 13 SLTU: unsigned compare
- 14 LUI: srcb << 16
- 15 MULT: bigresult = signed srca*srcb; 16 MULTU: bigresult = unsigned product
- 17 DIV: bigresult = {remainder, quotient}, signed, quotient truncated toward zero, remainder taking the sign of srca
- 18 DIVU: the unsigned equivalent of DIV.
REQ-017 For codes 15-18, aluout SHALL be 0; for all other codes, bigresult SHALL be 0.
REQ-018 Divide by zero (srcb = 0, codes 17/18) SHALL give quotient 32'hFFFFFFFF and remainder = srca.
REQ-019 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0.
REQ-020 Undefined codes 19-31 SHALL give aluout = 0 and bigresult = 0, so zero = 1.
REQ-021 zero SHALL be computed from aluout only, not from bigresult.
REQ-022 aluout_q, zero_q and bigresult_q SHALL update on every rising clk edge with one-cycle latency and no enable.

Reset
REQ-023 When reset is high at a rising clk edge, aluout_q SHALL be 0, zero_q SHALL be 1 and bigresult_q SHALL be 0.
REQ-024 Reset SHALL NOT affect the combinational outputs aluout, zero, bigresult, add_y or ext_out.
REQ-025 When reset is asserted and deasserted mid-stream, the registered outputs SHALL resume tracking the inputs on the first clock edge after deassertion.

Structure
REQ-026 The alucontrol code constants SHALL be defined as an enum, together with WIDTH, in a shared package mips_alu_pkg.
REQ-027 The combinational operation decode SHALL be placed in one sub-module, alu_core.
REQ-028 The adder, the zero extender and the output registers SHALL be implemented inline in mips_alu.

Verification
REQ-029 ADD with srca=32'hFFFFFFFF, srcb=1 -> aluout=0, zero=1; SUB with 5 and 7 -> aluout=32'hFFFFFFFE, zero=0.
REQ-030 SLT with srca=32'hFFFFFFFF, srcb=1 -> aluout 1; SLTU with the same operands -> aluout 0.
REQ-031 SRA with srcb=32'h80000000, shamt=4 -> 32'hF8000000; SRLV with srca=36, srcb=32'h80000000 -> 32'h08000000 (shift by 4); LUI with srcb=32'h1234 -> 32'h12340000.
REQ-032 MULT of -2 and 3 -> bigresult=64'hFFFFFFFF_FFFFFFFA; DIV of -7 by 2 -> bigresult={32'hFFFFFFFF, 32'hFFFFFFFD}; DIVU of 9 by 0 -> {32'h9, 32'hFFFFFFFF}.
REQ-033 add_a=32'h00400004, add_b=32'hFFFFFFF0 -> add_y=32'h003FFFF4; ext_in=16'h8001 -> ext_out=32'h00008001.
REQ-034 Reset held for 2 cycles -> aluout_q=0, zero_q=1, bigresult_q=0; after release, apply ADD 2+3 -> aluout_q=5 one cycle later.
